// File: rtl/timer_dev_if.sv
// Peripheral-bus view of the timer: word select, write strobe, write/read data
// and the interrupt line toward CP0.
interface timer_dev_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        IRQ;

    modport master (
        output Addr,
        output WE,
        output DataIn,
        input  DataOut,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WE,
        input  DataIn,
        output DataOut,
        output IRQ
    );
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped programmable down-counter with one-shot and auto-reload modes.
// Registers: CTRL (EN, MODE, IM), PRESET, COUNT (read-only).
module timer_dev #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000,
    parameter logic        IM_RST     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    timer_dev_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO   = 2'b01;

    state_t      state_q,     state_d;
    logic        ctrl_en_q,   ctrl_en_d;
    logic [1:0]  ctrl_mode_q, ctrl_mode_d;
    logic        ctrl_im_q,   ctrl_im_d;
    logic [31:0] preset_q,    preset_d;
    logic [31:0] count_q,     count_d;
    logic        irq_pend_q,  irq_pend_d;

    logic        wr_ctrl_s;
    logic        wr_preset_s;
    logic [31:0] rdata_s;

    assign wr_ctrl_s   = bus.WE && (bus.Addr == ADDR_CTRL);
    assign wr_preset_s = bus.WE && (bus.Addr == ADDR_PRESET);

    // Sequencer, counter, pending flag and bus register updates.
    always_comb begin
        state_d     = state_q;
        ctrl_en_d   = ctrl_en_q;
        ctrl_mode_d = ctrl_mode_q;
        ctrl_im_d   = ctrl_im_q;
        preset_d    = preset_q;
        count_d     = count_q;
        irq_pend_d  = irq_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_en_q) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // PRESET of 0 lands here straight after LOAD, same as PRESET of 1.
                    count_d = 32'd0;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                if (ctrl_mode_q == MODE_AUTO) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_en_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Setting the flag beats any clear arriving in the same cycle.
        if (state_q == ST_INT) begin
            irq_pend_d = 1'b1;
        end else if (wr_ctrl_s || wr_preset_s) begin
            irq_pend_d = 1'b0;
        end else if (irq_pend_q && (ctrl_mode_q == MODE_AUTO)) begin
            irq_pend_d = 1'b0;
        end else begin
            irq_pend_d = irq_pend_q;
        end

        // Software writes override the hardware EN clear.
        if (wr_ctrl_s) begin
            ctrl_en_d   = bus.DataIn[0];
            ctrl_mode_d = bus.DataIn[2:1];
            ctrl_im_d   = bus.DataIn[3];
        end else begin
            ctrl_mode_d = ctrl_mode_q;
            ctrl_im_d   = ctrl_im_q;
        end

        if (wr_preset_s) begin
            preset_d = bus.DataIn;
        end else begin
            preset_d = preset_q;
        end
    end

    // Register bank with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= 2'b00;
            ctrl_im_q   <= IM_RST;
            preset_q    <= PRESET_RST;
            count_q     <= 32'd0;
            irq_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_en_q   <= ctrl_en_d;
            ctrl_mode_q <= ctrl_mode_d;
            ctrl_im_q   <= ctrl_im_d;
            preset_q    <= preset_d;
            count_q     <= count_d;
            irq_pend_q  <= irq_pend_d;
        end
    end

    // Read-data selection.
    always_comb begin
        rdata_s = 32'd0;
        case (bus.Addr)
            ADDR_CTRL:   rdata_s = {28'd0, ctrl_im_q, ctrl_mode_q, ctrl_en_q};
            ADDR_PRESET: rdata_s = preset_q;
            ADDR_COUNT:  rdata_s = count_q;
            default:     rdata_s = 32'd0;
        endcase
    end

    assign bus.DataOut = rdata_s;
    assign bus.IRQ     = irq_pend_q & ctrl_im_q;

endmodule
